// File: rtl/ser_pkg.sv
// Shared types and lane-index helper for word_serializer.
// ser_next_idx finds the next enabled lane in the chosen order plus a none-left flag.
package ser_pkg;

   localparam int SER_LANES_MAX = 64;
   localparam int SER_IDX_MAX   = 6;

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_e;

   typedef struct packed {
      logic [SER_IDX_MAX-1:0] idx;
      logic                   none;
   } ser_nxt_t;

   // idx is the current lane. Pass LANES (MSB-first) or -1 (LSB-first)
   // to find the first lane of a word. Mask bits above LANES must be zero.
   function automatic ser_nxt_t ser_next_idx(
      input logic [SER_LANES_MAX-1:0] mask,
      input int                       idx,
      input logic                     msb_first
   );
      ser_nxt_t r;
      r.idx  = '0;
      r.none = 1'b1;
      if (msb_first) begin
         // ascending scan: the last hit is the highest lane below idx
         for (int k = 0; k < SER_LANES_MAX; k++) begin
            if (k < idx && mask[k]) begin
               r.idx  = k[SER_IDX_MAX-1:0];
               r.none = 1'b0;
            end
         end
      end else begin
         // descending scan: the last hit is the lowest lane above idx
         for (int k = SER_LANES_MAX-1; k >= 0; k--) begin
            if (k > idx && mask[k]) begin
               r.idx  = k[SER_IDX_MAX-1:0];
               r.none = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/word_serializer_lane_mux.sv
// lane_mux: combinational select of lane i_idx from a held word.
// Ports: i_word (WIDTH), i_idx (IDX_W), o_lane (LANE_W).
module lane_mux #(
   parameter int WIDTH  = 32,
   parameter int LANE_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic [WIDTH-1:0]  i_word,
   input  logic [IDX_W-1:0]  i_idx,
   output logic [LANE_W-1:0] o_lane
);

   localparam int LANES = WIDTH / LANE_W;

   always_comb begin
      o_lane = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i_idx == IDX_W'(i)) begin
            o_lane = i_word[i*LANE_W +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: takes a WIDTH word over valid/ready, emits LANES lanes
// MSB- or LSB-first. Ports: clk, reset, in_valid/in_ready/in_data/in_msb_first,
// out_valid/out_ready/out_data/out_idx/out_last.
// Macro SER_MASK_EN adds in_mask (LANES): per-lane enable, disabled lanes skipped.
module word_serializer
   import ser_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int LANE_W = 8,
   localparam int LANES  = WIDTH / LANE_W,
   localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_msb_first,
`ifdef SER_MASK_EN
   input  logic [LANES-1:0]  in_mask,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last
);

   ser_state_e r_state, w_state_nxt;
   logic [WIDTH-1:0] r_word, w_word_nxt;
   logic r_msb, w_msb_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic r_last, w_last_nxt;

   logic [LANES-1:0] w_mask_in;
   logic [LANES-1:0] w_mask_cur;
   logic [SER_LANES_MAX-1:0] w_in_ext;
   logic [SER_LANES_MAX-1:0] w_cur_ext;

   ser_nxt_t w_first, w_first2;
   ser_nxt_t w_step, w_step2;

   logic w_in_fire;
   logic w_beat;
   logic w_unused;

`ifdef SER_MASK_EN
   logic [LANES-1:0] r_mask;
   assign w_mask_in  = in_mask;
   assign w_mask_cur = r_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mask <= '0;
      end else if (w_in_fire) begin
         r_mask <= in_mask;
      end
   end
`else
   assign w_mask_in  = '1;
   assign w_mask_cur = '1;
`endif

   always_comb begin
      w_in_ext  = '0;
      w_cur_ext = '0;
      w_in_ext[LANES-1:0]  = w_mask_in;
      w_cur_ext[LANES-1:0] = w_mask_cur;
   end

   assign out_valid = (r_state == SEND);
   assign w_beat    = out_valid & out_ready;
   assign in_ready  = (r_state == IDLE) | (w_beat & r_last);
   assign w_in_fire = in_valid & in_ready;
   assign out_idx   = r_idx;
   assign out_last  = r_last;

   // first/first2: lane to start on and whether it is also the last.
   // step/step2: the same look-ahead from the lane currently shown.
   always_comb begin
      w_first  = ser_next_idx(w_in_ext,
                              in_msb_first ? LANES : -1,
                              in_msb_first);
      w_first2 = ser_next_idx(w_in_ext, int'(w_first.idx),
                              in_msb_first);
      w_step   = ser_next_idx(w_cur_ext, int'(r_idx), r_msb);
      w_step2  = ser_next_idx(w_cur_ext, int'(w_step.idx), r_msb);
   end

   assign w_unused = ^{w_first.idx, w_first2.idx,
                       w_step.idx, w_step.none, w_step2.idx};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_word  <= '0;
         r_msb   <= 1'b0;
         r_idx   <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_word  <= w_word_nxt;
         r_msb   <= w_msb_nxt;
         r_idx   <= w_idx_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Input fire only happens in IDLE or on the last beat, so it
   // takes priority over the plain advance.
   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      w_msb_nxt   = r_msb;
      w_idx_nxt   = r_idx;
      w_last_nxt  = r_last;
      if (w_in_fire) begin
         w_word_nxt = in_data;
         w_msb_nxt  = in_msb_first;
         if (w_first.none) begin
            // nothing enabled: word consumed silently
            w_state_nxt = IDLE;
            w_last_nxt  = 1'b0;
         end else begin
            w_state_nxt = SEND;
            w_idx_nxt   = w_first.idx[IDX_W-1:0];
            w_last_nxt  = w_first2.none;
         end
      end else if (w_beat) begin
         if (r_last) begin
            w_state_nxt = IDLE;
            w_last_nxt  = 1'b0;
         end else begin
            w_idx_nxt  = w_step.idx[IDX_W-1:0];
            w_last_nxt = w_step2.none;
         end
      end
   end

   lane_mux #(
      .WIDTH  (WIDTH),
      .LANE_W (LANE_W),
      .IDX_W  (IDX_W)
   ) u_lane_mux (
      .i_word (r_word),
      .i_idx  (r_idx),
      .o_lane (out_data)
   );

endmodule
